// File: rtl/transposer_pkg.sv
// Shared types and default geometry for the ping-pong transposer.
package transposer_pkg;

   localparam int unsigned DIM = 16;
   localparam int unsigned EW  = 8;

   typedef logic [EW-1:0] elem_t;
   typedef elem_t row_t [DIM];

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_state_t;

endpackage

// File: rtl/pingpong_transposer_bank.sv
// One DIMxDIM storage bank: row-wide write port, column (or row, in bypass) read mux.
module transposer_bank
   import transposer_pkg::*;
#(
   parameter int unsigned DIM = transposer_pkg::DIM,
   parameter int unsigned EW  = transposer_pkg::EW
) (
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [$clog2(DIM)-1:0] wr_idx,
   input  logic [DIM*EW-1:0]      wr_data,
   input  logic [$clog2(DIM)-1:0] rd_idx,
   input  logic                   bypass,
   output logic [DIM*EW-1:0]      rd_data
);

   logic [EW-1:0] mem [DIM][DIM];

   // Store an accepted row; data needs no reset since emptiness is tracked by the top.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned j = 0; j < DIM; j++) begin
            mem[wr_idx][j] <= wr_data[j*EW +: EW];
         end
      end
   end

   // Output element j: row j of column rd_idx, or element j of row rd_idx when bypassed.
   always_comb begin
      rd_data = '0;
      for (int unsigned j = 0; j < DIM; j++) begin
         rd_data[j*EW +: EW] = bypass ? mem[rd_idx][j] : mem[j][rd_idx];
      end
   end

endmodule

// File: rtl/pingpong_transposer.sv
// Streaming DIMxDIM transposer: one bank fills with rows while the other drains columns.
module pingpong_transposer
   import transposer_pkg::*;
#(
   parameter int unsigned DIM = transposer_pkg::DIM,
   parameter int unsigned EW  = transposer_pkg::EW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIM*EW-1:0] in_data,
   input  logic              in_bypass,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DIM*EW-1:0] out_data,
   output logic              out_last
);

   localparam int unsigned     CW   = $clog2(DIM);
   localparam logic [CW-1:0]   LAST = CW'(DIM - 1);

   bank_state_t       bank_st [2];
   bank_state_t       bank_st_nxt [2];
   logic              byp [2];
   logic              byp_nxt [2];
   logic              wr_bank, wr_bank_nxt;
   logic              rd_bank, rd_bank_nxt;
   logic [CW-1:0]     wr_cnt, wr_cnt_nxt;
   logic [CW-1:0]     rd_cnt, rd_cnt_nxt;
   logic              wr_fire, rd_fire;
   logic [DIM*EW-1:0] bank_rd [2];

   assign in_ready  = (bank_st[wr_bank] != FULL);
   assign out_valid = (bank_st[rd_bank] == FULL);
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;

   // Write fills a non-FULL bank and read drains a FULL one, so they never target the same bank.
   always_comb begin
      bank_st_nxt = bank_st;
      byp_nxt     = byp;
      wr_bank_nxt = wr_bank;
      rd_bank_nxt = rd_bank;
      wr_cnt_nxt  = wr_cnt;
      rd_cnt_nxt  = rd_cnt;
      if (wr_fire) begin
         if (wr_cnt == '0) begin
            byp_nxt[wr_bank] = in_bypass;
         end
         if (wr_cnt == LAST) begin
            bank_st_nxt[wr_bank] = FULL;
            wr_cnt_nxt           = '0;
            wr_bank_nxt          = ~wr_bank;
         end else begin
            bank_st_nxt[wr_bank] = FILLING;
            wr_cnt_nxt           = wr_cnt + 1'b1;
         end
      end
      if (rd_fire) begin
         if (rd_cnt == LAST) begin
            bank_st_nxt[rd_bank] = EMPTY;
            rd_cnt_nxt           = '0;
            rd_bank_nxt          = ~rd_bank;
         end else begin
            rd_cnt_nxt           = rd_cnt + 1'b1;
         end
      end
   end

   // Control state register; reset drops all in-flight blocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            bank_st[i] <= EMPTY;
            byp[i]     <= 1'b0;
         end
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
      end else begin
         bank_st <= bank_st_nxt;
         byp     <= byp_nxt;
         wr_bank <= wr_bank_nxt;
         rd_bank <= rd_bank_nxt;
         wr_cnt  <= wr_cnt_nxt;
         rd_cnt  <= rd_cnt_nxt;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      transposer_bank #(
         .DIM (DIM),
         .EW  (EW)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_fire && (wr_bank == 1'(b))),
         .wr_idx  (wr_cnt),
         .wr_data (in_data),
         .rd_idx  (rd_cnt),
         .bypass  (byp[b]),
         .rd_data (bank_rd[b])
      );
   end

   assign out_data = out_valid ? bank_rd[rd_bank] : '0;
   assign out_last = out_valid && (rd_cnt == LAST);

endmodule

// File: tb/tb_pingpong_transposer.sv
// Directed and randomized checks of the ping-pong transposer at DIM=4, EW=8.
module tb_pingpong_transposer;

   localparam int unsigned DIM = 4;
   localparam int unsigned EW  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = '0;
   logic          in_bypass = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_data;
   logic          out_last;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pingpong_transposer #(
      .DIM (DIM),
      .EW  (EW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_bypass (in_bypass),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   // Row i of a block: element j = seed + 16*i + j.
   function automatic logic [31:0] row_of(input logic [7:0] seed, input int i);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(int'(seed) + i*16 + j);
      return r;
   endfunction

   // Expected output vector k: column k (element j = row j, elem k), or row k if bypassed.
   function automatic logic [31:0] vec_of(input logic [7:0] seed, input int k, input logic byp);
      logic [31:0] v;
      v = '0;
      for (int j = 0; j < 4; j++)
         v[j*8 +: 8] = byp ? 8'(int'(seed) + k*16 + j) : 8'(int'(seed) + j*16 + k);
      return v;
   endfunction

   // Advance one cycle: sample at the falling edge, return after the next rising edge.
   task automatic step(output logic acc, output logic got, output logic [31:0] od,
                       output logic ol, output logic ir, output logic ov);
      @(negedge clk);
      ir  = in_ready;
      ov  = out_valid;
      acc = in_valid && in_ready;
      got = out_valid && out_ready;
      od  = out_data;
      ol  = out_last;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic acc, got, ol, ir, ov;
      logic [31:0] od;
      int nout;
      out_ready = 1'b1;
      in_bypass = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = row_of(8'h00, i);
         step(acc, got, od, ol, ir, ov);
         checks++;
         if (acc !== 1'b1 || got !== 1'b0) begin
            failures++; $display("FAIL basic_fill row%0d acc=%b got=%b exp acc=1 got=0", i, acc, got);
         end
      end
      in_valid = 1'b0;
      in_data  = '0;
      nout = 0;
      for (int c = 0; c < 10 && nout < 4; c++) begin
         step(acc, got, od, ol, ir, ov);
         if (c == 0) begin
            checks++;
            if (ov !== 1'b1) begin failures++; $display("FAIL basic_latency out_valid=%b exp=1", ov); end
         end
         if (got) begin
            checks++;
            if (od !== vec_of(8'h00, nout, 1'b0) || ol !== (nout == 3)) begin
               failures++;
               $display("FAIL basic_col%0d got=%h last=%b exp=%h last=%b", nout, od, ol, vec_of(8'h00, nout, 1'b0), nout == 3);
            end
            nout++;
         end
      end
      checks++; if (nout != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", nout); end
   endtask

   task automatic test_back_to_back();
      logic acc, got, ol, ir, ov;
      logic [31:0] od;
      int sent, nout, first, lastc, drops;
      sent = 0; nout = 0; first = -1; lastc = -1; drops = 0;
      out_ready = 1'b1;
      in_bypass = 1'b0;
      for (int c = 0; c < 40 && nout < 12; c++) begin
         in_valid = (sent < 12);
         in_data  = row_of(8'((sent / 4) * 64), sent % 4);
         step(acc, got, od, ol, ir, ov);
         if (in_valid && !ir) drops++;
         if (acc) sent++;
         if (got) begin
            if (first < 0) first = c;
            lastc = c;
            checks++;
            if (od !== vec_of(8'((nout / 4) * 64), nout % 4, 1'b0) || ol !== (nout % 4 == 3)) begin
               failures++;
               $display("FAIL b2b_vec%0d got=%h last=%b exp=%h last=%b", nout, od, ol,
                        vec_of(8'((nout / 4) * 64), nout % 4, 1'b0), nout % 4 == 3);
            end
            nout++;
         end
      end
      in_valid = 1'b0;
      checks++; if (drops != 0) begin failures++; $display("FAIL b2b_in_ready_drops got=%0d exp=0", drops); end
      checks++; if (nout != 12) begin failures++; $display("FAIL b2b_count got=%0d exp=12", nout); end
      checks++; if (lastc - first != 11) begin failures++; $display("FAIL b2b_bubbles span=%0d exp=11", lastc - first); end
   endtask

   task automatic test_backpressure();
      logic acc, got, ol, ir, ov;
      logic [31:0] od, ref_od;
      logic have_ref;
      int sent, nout, unstable;
      sent = 0; nout = 0; unstable = 0; have_ref = 1'b0; ref_od = '0;
      ir = 1'b1; ov = 1'b0; ol = 1'b1;
      out_ready = 1'b0;
      in_bypass = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1;
         in_data  = row_of(8'(8'h11 * (sent / 4 + 1)), sent % 4);
         step(acc, got, od, ol, ir, ov);
         if (acc) sent++;
         if (ov) begin
            if (!have_ref) begin ref_od = od; have_ref = 1'b1; end
            else if (od !== ref_od) unstable++;
         end
      end
      checks++; if (sent != 8) begin failures++; $display("FAIL bp_accepted got=%0d exp=8", sent); end
      checks++; if (ir !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", ir); end
      checks++; if (ov !== 1'b1 || ol !== 1'b0) begin failures++; $display("FAIL bp_out_valid got=%b last=%b exp=1 last=0", ov, ol); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable changes=%0d exp=0", unstable); end
      checks++; if (ref_od !== vec_of(8'h11, 0, 1'b0)) begin failures++; $display("FAIL bp_held got=%h exp=%h", ref_od, vec_of(8'h11, 0, 1'b0)); end
      out_ready = 1'b1;
      for (int c = 0; c < 40 && nout < 12; c++) begin
         in_valid = (sent < 12);
         in_data  = row_of(8'(8'h11 * (sent / 4 + 1)), sent % 4);
         step(acc, got, od, ol, ir, ov);
         if (acc) sent++;
         if (got) begin
            checks++;
            if (od !== vec_of(8'(8'h11 * (nout / 4 + 1)), nout % 4, 1'b0) || ol !== (nout % 4 == 3)) begin
               failures++;
               $display("FAIL bp_vec%0d got=%h last=%b exp=%h last=%b", nout, od, ol,
                        vec_of(8'(8'h11 * (nout / 4 + 1)), nout % 4, 1'b0), nout % 4 == 3);
            end
            nout++;
         end
      end
      in_valid = 1'b0;
      checks++; if (nout != 12 || sent != 12) begin failures++; $display("FAIL bp_drain out=%0d in=%0d exp 12/12", nout, sent); end
   endtask

   task automatic test_bypass();
      logic acc, got, ol, ir, ov;
      logic [31:0] od;
      logic [7:0] seed;
      logic byp;
      int nout;
      out_ready = 1'b1;
      // Block 0 bypassed via row 0; block 1 has bypass only on rows 1..3, which is ignored.
      for (int b = 0; b < 2; b++) begin
         seed = (b == 0) ? 8'h05 : 8'h4A;
         byp  = (b == 0);
         for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_bypass = (b == 0) ? (i == 0) : (i != 0);
            in_data   = row_of(seed, i);
            step(acc, got, od, ol, ir, ov);
            checks++;
            if (acc !== 1'b1) begin failures++; $display("FAIL byp_accept blk%0d row%0d got=%b exp=1", b, i, acc); end
         end
         in_valid  = 1'b0;
         in_bypass = 1'b0;
         nout = 0;
         for (int c = 0; c < 10 && nout < 4; c++) begin
            step(acc, got, od, ol, ir, ov);
            if (got) begin
               checks++;
               if (od !== vec_of(seed, nout, byp) || ol !== (nout == 3)) begin
                  failures++;
                  $display("FAIL byp_vec blk%0d v%0d got=%h last=%b exp=%h last=%b", b, nout, od, ol, vec_of(seed, nout, byp), nout == 3);
               end
               nout++;
            end
         end
         checks++; if (nout != 4) begin failures++; $display("FAIL byp_count blk%0d got=%0d exp=4", b, nout); end
      end
   endtask

   task automatic test_random();
      logic acc, got, ol, ir, ov;
      logic [31:0] od, v;
      logic [32:0] e;
      logic [32:0] exp_q [$];
      logic [31:0] rows [4];
      logic rbyp;
      int rcnt, bcnt, nout;
      rcnt = 0; bcnt = 0; nout = 0; rbyp = 1'b0;
      for (int c = 0; c < 20000 && (bcnt < 100 || exp_q.size() > 0); c++) begin
         in_valid  = (bcnt < 100) && ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_bypass = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 2) != 0);
         step(acc, got, od, ol, ir, ov);
         if (acc) begin
            if (rcnt == 0) rbyp = in_bypass;
            rows[rcnt] = in_data;
            rcnt++;
            if (rcnt == 4) begin
               for (int k = 0; k < 4; k++) begin
                  v = '0;
                  for (int j = 0; j < 4; j++)
                     v[j*8 +: 8] = rbyp ? rows[k][j*8 +: 8] : rows[j][k*8 +: 8];
                  exp_q.push_back({(k == 3), v});
               end
               rcnt = 0;
               bcnt++;
            end
         end
         if (got) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL rand_unexpected got=%h exp=none", od);
            end else begin
               e = exp_q.pop_front();
               if ({ol, od} !== e) begin
                  failures++; $display("FAIL rand_vec%0d got=%b/%h exp=%b/%h", nout, ol, od, e[32], e[31:0]);
               end
            end
            nout++;
         end
      end
      in_valid  = 1'b0;
      in_bypass = 1'b0;
      out_ready = 1'b1;
      checks++; if (bcnt != 100 || nout != 400 || exp_q.size() != 0)
         begin failures++; $display("FAIL rand_totals blocks=%0d vecs=%0d pending=%0d exp 100/400/0", bcnt, nout, exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic acc, got, ol, ir, ov;
      logic [31:0] od;
      int sent, nout, extra;
      sent = 0; nout = 0; extra = 0;
      out_ready = 1'b0;
      in_bypass = 1'b0;
      for (int c = 0; c < 20 && sent < 7; c++) begin
         in_valid = 1'b1;
         in_data  = row_of((sent < 4) ? 8'h31 : 8'h62, sent % 4);
         step(acc, got, od, ol, ir, ov);
         if (acc) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && nout < 2; c++) begin
         step(acc, got, od, ol, ir, ov);
         if (got) begin
            checks++;
            if (od !== vec_of(8'h31, nout, 1'b0)) begin failures++; $display("FAIL rmid_pre_vec%0d got=%h exp=%h", nout, od, vec_of(8'h31, nout, 1'b0)); end
            nout++;
         end
      end
      checks++; if (sent != 7 || nout != 2) begin failures++; $display("FAIL rmid_setup in=%0d out=%0d exp 7/2", sent, nout); end
      out_ready = 1'b0;
      rst = 1'b1;
      #2;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmid_reset out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
      checks++; if (out_data !== 32'h0 || out_last !== 1'b0) begin failures++; $display("FAIL rmid_reset_data got=%h last=%b exp=00000000 last=0", out_data, out_last); end
      rst = 1'b0;
      sent = 0; nout = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 30 && nout < 4; c++) begin
         in_valid = (sent < 4);
         in_data  = row_of(8'hC4, sent % 4);
         step(acc, got, od, ol, ir, ov);
         if (acc) sent++;
         if (got) begin
            checks++;
            if (od !== vec_of(8'hC4, nout, 1'b0) || ol !== (nout == 3)) begin
               failures++; $display("FAIL rmid_vec%0d got=%h last=%b exp=%h last=%b", nout, od, ol, vec_of(8'hC4, nout, 1'b0), nout == 3);
            end
            nout++;
         end
      end
      in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step(acc, got, od, ol, ir, ov);
         if (got) extra++;
      end
      checks++; if (nout != 4 || extra != 0) begin failures++; $display("FAIL rmid_count got=%0d extra=%0d exp 4/0", nout, extra); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_bypass();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
